// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction memory loader:
//   LEN_W   - width of the word-count header carried in the byte stream
//   state_e - loader FSM state encoding
//   len_ok  - header sanity check (non-zero and fits in memory)
package imem_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // Unsigned compare; a zero-length load is treated as an error.
  function automatic logic len_ok(input logic [LEN_W-1:0] n,
                                  input logic [LEN_W-1:0] depth);
    return (n != '0) && (n <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_pack.sv
// imem_loader_pack
// Byte-to-word assembler. Bytes arrive little-endian: the first byte of a
// word ends up in bits [7:0], the fourth in bits [31:24].
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   clr       - synchronous clear of the byte counter and word register
//   shift_en  - shift byte_in into the word, advance the byte counter
//   byte_in   - incoming stream byte
//   word      - assembled word (valid once four bytes have been shifted)
//   last_byte - the next shifted byte completes the word
module imem_loader_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
    end else if (clr) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
    end else if (shift_en) begin
      // Shifting in from the top leaves the first byte at [7:0] after four.
      word_q     <= {byte_in, word_q[31:8]};
      byte_idx_q <= byte_idx_q + 2'd1;
    end
  end

  assign word      = word_q;
  assign last_byte = (byte_idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Loads a program into instruction memory from a byte stream:
// 2-byte little-endian word count N, then 4*N little-endian word bytes.
// The core is held in reset for the whole load and released on success.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   load_req   - start pulse, honoured only in IDLE
//   in_valid   - byte source has a byte on in_data
//   in_data    - stream byte
//   in_ready   - loader accepts a byte this cycle
//   imem_we    - instruction memory write strobe, one cycle per word
//   imem_addr  - word address of the write
//   imem_wdata - word to write
//   core_rst_n - active-low reset to the processor core
//   busy       - load in progress
//   done       - one-cycle pulse on successful completion
//   err        - sticky length error, cleared by the next load_req
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | waiting for load_req
// LEN_LO   | accept low byte of word count
// LEN_HI   | accept high byte of word count, validate it
// DATA     | accept word bytes into the assembler
// WRITE    | one-cycle memory write of the assembled word
// DONE     | pulse done, release the core
// ERR      | flag length error, core stays held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic              err_q;
  logic              core_rst_n_q;

  logic              accept;
  logic [LEN_W-1:0]  len_full;
  logic              last_word;
  logic              pack_clr;
  logic              pack_en;
  logic              last_byte;
  logic [31:0]       pack_word;

  // Outputs decode from registered state only; in_valid never reaches them.
  assign in_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA);
  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, len_q[7:0]};
  assign last_word = (LEN_W'(word_idx_q) == (len_q - LEN_W'(1)));

  assign pack_clr = (state_q == ST_IDLE) && load_req;
  assign pack_en  = (state_q == ST_DATA) && accept;

  imem_loader_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .clr       (pack_clr),
    .shift_en  (pack_en),
    .byte_in   (in_data),
    .word      (pack_word),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_req) begin
            state_q      <= ST_LEN_LO;
            len_q        <= '0;
            word_idx_q   <= '0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= in_data;
            state_q    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len_q   <= len_full;
            state_q <= len_ok(len_full, LEN_W'(DEPTH_WORDS)) ? ST_DATA : ST_ERR;
          end
        end
        ST_DATA: begin
          if (accept && last_byte) state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (last_word) begin
            state_q <= ST_DONE;
          end else begin
            word_idx_q <= word_idx_q + ADDR_W'(1);
            state_q    <= ST_DATA;
          end
        end
        ST_DONE: begin
          core_rst_n_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        ST_ERR: begin
          err_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = word_idx_q;
  assign imem_wdata = pack_word;
  assign core_rst_n = core_rst_n_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int DEPTH_WORDS = 256;
  localparam int ADDR_W      = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_req = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                done_cnt = 0;
  logic [7:0]        tx_q[$];

  imem_loader #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Write / done log, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit want_ready);
    int budget;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    if (want_ready) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL ready_after_gap byte=%h got=%b want=1", b, in_ready);
      end
    end
    budget = 0;
    while (in_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout byte=%h got=%b want=1", b, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int gap);
    foreach (tx_q[i]) send_byte(tx_q[i], gap, gap > 0);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, busy, done, err} !== 46'd0) begin
      failures++;
      $display("FAIL reset_values got=%b/%b/%h/%h/%b/%b/%b/%b want=all zero",
               in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, busy, done, err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, in_ready, core_rst_n} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b want=000", {busy, in_ready, core_rst_n});
    end
  endtask

  task automatic test_basic();
    int base = wr_addr.size();
    int dbase = done_cnt;
    pulse_load();
    checks++;
    if ({busy, in_ready, core_rst_n} !== 3'b110) begin
      failures++;
      $display("FAIL basic_start got=%b want=110", {busy, in_ready, core_rst_n});
    end
    tx_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    send_stream(0);
    checks++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'd1, 32'h0010_0113}) begin
      failures++;
      $display("FAIL basic_last_write got=%b/%h/%h want=1/01/00100113", imem_we, imem_addr, imem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({done, core_rst_n, busy} !== 3'b101) begin
      failures++;
      $display("FAIL basic_done_cycle got=%b want=101", {done, core_rst_n, busy});
    end
    @(negedge clk);
    checks++;
    if ({done, core_rst_n, busy, err} !== 4'b0100) begin
      failures++;
      $display("FAIL basic_release got=%b want=0100", {done, core_rst_n, busy, err});
    end
    checks++;
    if (wr_addr.size() - base != 2 || done_cnt - dbase != 1) begin
      failures++;
      $display("FAIL basic_counts writes=%0d dones=%0d want 2/1", wr_addr.size() - base, done_cnt - dbase);
    end else begin
      checks++;
      if (wr_addr[base] !== 8'd0 || wr_data[base] !== 32'h0050_0093) begin
        failures++;
        $display("FAIL basic_word0 got=%h/%h want=00/00500093", wr_addr[base], wr_data[base]);
      end
      checks++;
      if (wr_addr[base+1] !== 8'd1 || wr_data[base+1] !== 32'h0010_0113) begin
        failures++;
        $display("FAIL basic_word1 got=%h/%h want=01/00100113", wr_addr[base+1], wr_data[base+1]);
      end
    end
  endtask

  task automatic test_gaps();
    int base = wr_addr.size();
    int dbase = done_cnt;
    pulse_load();
    tx_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    send_stream(3);
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr.size() - base != 2 || done_cnt - dbase != 1 || core_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL gaps_counts writes=%0d dones=%0d core_rst_n=%b want 2/1/1",
               wr_addr.size() - base, done_cnt - dbase, core_rst_n);
    end else begin
      checks++;
      if ({wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]} !==
          {8'd0, 32'h0050_0093, 8'd1, 32'h0010_0113}) begin
        failures++;
        $display("FAIL gaps_words got=%h/%h %h/%h want=00/00500093 01/00100113",
                 wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
      end
    end
  endtask

  task automatic test_len_zero();
    int base = wr_addr.size();
    pulse_load();
    checks++;
    if (core_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL zero_core_held got=%b want=0", core_rst_n);
    end
    tx_q = '{8'h00, 8'h00};
    send_stream(0);
    checks++;
    if ({busy, err} !== 2'b10) begin
      failures++;
      $display("FAIL zero_err_cycle got=%b want=10", {busy, err});
    end
    @(negedge clk);
    checks++;
    if ({err, busy, core_rst_n, wr_addr.size() != base} !== 4'b1000) begin
      failures++;
      $display("FAIL zero_result err=%b busy=%b core_rst_n=%b writes=%0d want 1/0/0/0",
               err, busy, core_rst_n, wr_addr.size() - base);
    end
  endtask

  task automatic test_err_clear();
    int base = wr_addr.size();
    pulse_load();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got=%b want=0", err);
    end
    tx_q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_stream(0);
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr.size() - base != 1 || core_rst_n !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL one_word_load writes=%0d core_rst_n=%b err=%b want 1/1/0",
               wr_addr.size() - base, core_rst_n, err);
    end else begin
      checks++;
      if (wr_addr[base] !== 8'd0 || wr_data[base] !== 32'h1234_5678) begin
        failures++;
        $display("FAIL one_word_data got=%h/%h want=00/12345678", wr_addr[base], wr_data[base]);
      end
    end
  endtask

  task automatic test_len_over();
    int base = wr_addr.size();
    pulse_load();
    tx_q = '{8'h01, 8'h01};
    send_stream(0);
    repeat (6) @(negedge clk);
    checks++;
    if ({err, busy, core_rst_n, in_ready} !== 4'b1000 || wr_addr.size() != base) begin
      failures++;
      $display("FAIL over_len err=%b busy=%b core_rst_n=%b in_ready=%b writes=%0d want 1/0/0/0/0",
               err, busy, core_rst_n, in_ready, wr_addr.size() - base);
    end
  endtask

  task automatic test_full();
    int base = wr_addr.size();
    int dbase = done_cnt;
    logic [31:0] w;
    int bad = 0;
    pulse_load();
    tx_q = '{8'h00, 8'h01};
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      w = {8'(i) ^ 8'h5A, 8'hC3, ~8'(i), 8'(i)};
      tx_q.push_back(w[7:0]);
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[23:16]);
      tx_q.push_back(w[31:24]);
    end
    send_stream(0);
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr.size() - base != DEPTH_WORDS || done_cnt - dbase != 1 || core_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL full_counts writes=%0d dones=%0d core_rst_n=%b want %0d/1/1",
               wr_addr.size() - base, done_cnt - dbase, core_rst_n, DEPTH_WORDS);
    end else begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        w = {8'(i) ^ 8'h5A, 8'hC3, ~8'(i), 8'(i)};
        checks++;
        if (wr_addr[base+i] !== 8'(i) || wr_data[base+i] !== w) begin
          failures++;
          bad++;
          if (bad < 5)
            $display("FAIL full_word%0d got=%h/%h want=%h/%h", i, wr_addr[base+i], wr_data[base+i], 8'(i), w);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int base = wr_addr.size();
    pulse_load();
    tx_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
    send_stream(0);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, busy, done, err} !== 46'd0) begin
      failures++;
      $display("FAIL midreset_values got=%b/%b/%h/%h/%b/%b/%b/%b want=all zero",
               in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, busy, done, err);
    end
    checks++;
    if (wr_addr.size() - base != 1) begin
      failures++;
      $display("FAIL midreset_partial writes=%0d want=1", wr_addr.size() - base);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_basic();
  endtask

  task automatic test_load_ignored();
    int base = wr_addr.size();
    int dbase = done_cnt;
    pulse_load();
    tx_q = '{8'h02, 8'h00, 8'h93, 8'h00};
    send_stream(0);
    pulse_load();
    checks++;
    if ({busy, in_ready, err, core_rst_n} !== 4'b1100) begin
      failures++;
      $display("FAIL ignored_load_state got=%b want=1100", {busy, in_ready, err, core_rst_n});
    end
    tx_q = '{8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    send_stream(0);
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr.size() - base != 2 || done_cnt - dbase != 1) begin
      failures++;
      $display("FAIL ignored_counts writes=%0d dones=%0d want 2/1", wr_addr.size() - base, done_cnt - dbase);
    end else begin
      checks++;
      if ({wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]} !==
          {8'd0, 32'h0050_0093, 8'd1, 32'h0010_0113}) begin
        failures++;
        $display("FAIL ignored_words got=%h/%h %h/%h want=00/00500093 01/00100113",
                 wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_len_zero();
    test_err_clear();
    test_len_over();
    test_full();
    test_reset_mid();
    test_load_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes instruction memory, the write-side counterpart to the processor's read-only instruction fetch path. It accepts a byte stream (length header plus little-endian instruction words) over a valid/ready interface and issues word writes to instruction memory. It holds the core in reset for the whole load, then releases it. It sits between a host byte source (UART receiver or testbench) and the instruction memory write port.

## Interface
Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words
- ADDR_W, 8, word-address width; must satisfy 2^ADDR_W >= DEPTH_WORDS

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- load_req  in  1  single-cycle pulse; starts a load when the FSM is in IDLE
- in_valid  in  1  byte source has a byte on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  word to write
- core_rst_n  out  1  active-low reset to the processor core
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when a load completes successfully
- err  out  1  sticky length error; cleared by the next accepted load_req

## Operation
- A byte is accepted when in_valid && in_ready.
- Stream format:
  - byte 0 = N[7:0], byte 1 = N[15:8], giving N as the word count
  - then 4·N bytes; for each word, the first byte becomes bits [7:0] and the fourth byte becomes bits [31:24]
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- IDLE: in_ready=0. load_req → LEN_LO; clear err, word_idx and byte_idx.
- LEN_LO: in_ready=1. Accepted byte → N[7:0], go to LEN_HI.
- LEN_HI: in_ready=1. Accepted byte → N[15:8].
  - If N==0 or N>DEPTH_WORDS → ERR.
  - Otherwise → DATA.
- DATA: in_ready=1. Each accepted byte is shifted into the assembler and byte_idx increments (2-bit counter, wraps 3→0). The fourth accepted byte → WRITE.
- WRITE: in_ready=0, imem_we=1, imem_addr=word_idx, imem_wdata=assembled word.
  - If word_idx==N-1 → DONE.
  - Otherwise word_idx+1 and → DATA.
- DONE: done=1 for one cycle, core_rst_n set to 1, → IDLE.
- ERR: err set to 1, → IDLE. core_rst_n stays 0, and no further writes occur.
- load_req outside IDLE is ignored.
- busy=1 in every state except IDLE.
- core_rst_n:
  - reset value 0
  - cleared to 0 on the load_req that leaves IDLE
  - set to 1 only in DONE
  - the core stays held after an error
- A partial load aborted by rst leaves already-written words in memory; the core stays held (core_rst_n=0).

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, err=0. The FSM resets to IDLE. All state and outputs clear asynchronously on rst=0.
- All outputs are registered or decoded from the registered state only. There is no combinational path from in_valid or in_data to any output.
- load_req at edge k: busy=1, core_rst_n=0 and in_ready=1 from cycle k+1.
- The fourth data byte of a word is accepted at edge k; imem_we=1 during cycle k+1. imem_addr and imem_wdata are stable for that whole cycle.
- Minimum 5 cycles per word (4 accept + 1 write). Gaps in in_valid stall the FSM indefinitely without a timeout.
- Last write in cycle k → done=1 in cycle k+1; core_rst_n=1 and busy=0 from cycle k+2.
- LEN_HI byte accepted at edge k with an invalid N → ERR in cycle k+1; err=1 and busy=0 from cycle k+2.
- Arithmetic and widths:
  - N is 16 bits, compared unsigned against DEPTH_WORDS.
  - word_idx is ADDR_W bits and never exceeds N-1, so it never wraps.

## Structure
- Package imem_loader_pkg holds the state enum (IDLE..ERR) and the LEN_W=16 constant.
- One sub-module, imem_loader_pack: byte-to-word shift assembler with a 2-bit byte counter. It has a "last byte" flag output and a clear input.

## Test plan
- N=2, bytes 02 00 93 00 50 00 13 01 10 00 with in_valid held high → writes addr 0 = 0x00500093 and addr 1 = 0x00100113. done pulses once, then core_rst_n=1.
- The same stream with in_valid deasserted for 3 cycles between every byte → identical writes. in_ready never drops in DATA, and imem_we is never asserted twice for the same word.
- N=0 → no imem_we, err=1, core_rst_n=0, busy=0. A subsequent valid load clears err.
- N=DEPTH_WORDS+1 (0x0101 with defaults) → err=1, no writes. N=DEPTH_WORDS=256 → 256 writes, addr 0..255, then done.
- rst=0 pulsed mid-word during word 1 → all outputs return to reset values immediately, and a fresh load then completes correctly.
- load_req pulsed during DATA → ignored: word_idx, byte_idx and the stream position are unchanged.
